// File: rtl/stage_mem.sv
// stage_mem : memory-access stage between the EX/MEM and MEM/WB latches.
//   Non-memory instructions pass straight through in the same cycle.
//   Loads and stores run over a byte-wide memory port, one byte per accepted
//   request. Upstream is held with stall_mem until the access finishes.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | pass-through, or issue byte 0 of a new memory access
//   BUSY  | request byte cnt, waiting for mem_ready
//   DONE  | one cycle: present the load/store result, release upstream
//
// Ports
//   clock, reset                 clock and async active-high reset
//   write_i/regw_addr_i/data_i   instruction result from EX/MEM
//   load, store, mem_length,     memory op control; data_i holds the
//   mem_signed, mem_write_data   effective address when load|store
//   mem_req/rw/addr/wdata,       byte-wide memory port
//   mem_ready/rdata
//   stall_mem                    hold upstream stages
//   write_o/regw_addr_o/data_o   to MEM/WB latch
module stage_mem #(
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      write_i,
   input  logic [REG_ADDR_WIDTH-1:0] regw_addr_i,
   input  logic [31:0]               regw_data_i,
   input  logic                      load,
   input  logic                      store,
   input  logic [31:0]               mem_write_data,
   input  logic [2:0]                mem_length,
   input  logic                      mem_signed,
   input  logic                      mem_ready,
   input  logic [7:0]                mem_rdata,
   output logic                      mem_req,
   output logic                      mem_rw,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [7:0]                mem_wdata,
   output logic                      stall_mem,
   output logic                      write_o,
   output logic [REG_ADDR_WIDTH-1:0] regw_addr_o,
   output logic [31:0]               regw_data_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [1:0]  cnt;
   logic [31:0] data_q;
   logic [1:0]  last_idx;
   logic        mem_op;
   logic        access;
   logic        last;
   logic [31:0] load_ext;

   assign mem_op = load | store;

   // Any length other than 1 or 2 behaves as a word access.
   assign last_idx = (mem_length == 3'd1) ? 2'd0 :
                     (mem_length == 3'd2) ? 2'd1 : 2'd3;
   assign last     = (cnt == last_idx);

   // Byte 0 is requested already in the IDLE cycle the op arrives.
   assign access = ((state == IDLE) && mem_op) || (state == BUSY);

   always_comb begin
      load_ext = data_q;
      if (mem_length == 3'd1)
         load_ext = {{24{mem_signed & data_q[7]}}, data_q[7:0]};
      else if (mem_length == 3'd2)
         load_ext = {{16{mem_signed & data_q[15]}}, data_q[15:0]};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 2'd0;
         data_q <= 32'd0;
      end else begin
         case (state)
            IDLE, BUSY: begin
               if (access && mem_ready) begin
                  if (!store)
                     data_q[8*cnt +: 8] <= mem_rdata;
                  if (last) begin
                     cnt   <= 2'd0;
                     state <= DONE;
                  end else begin
                     cnt   <= cnt + 2'd1;
                     state <= BUSY;
                  end
               end else if (access) begin
                  state <= BUSY;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are forced low while reset is high, including the
   // combinational request path.
   always_comb begin
      mem_req     = 1'b0;
      mem_rw      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = 8'd0;
      stall_mem   = 1'b0;
      write_o     = 1'b0;
      regw_addr_o = '0;
      regw_data_o = 32'd0;
      if (!reset) begin
         mem_rw    = store;
         mem_addr  = ADDR_WIDTH'(regw_data_i) + ADDR_WIDTH'(cnt);
         mem_wdata = mem_write_data[8*cnt +: 8];
         case (state)
            IDLE: begin
               if (mem_op) begin
                  mem_req   = 1'b1;
                  stall_mem = 1'b1;
               end else begin
                  write_o     = write_i;
                  regw_addr_o = regw_addr_i;
                  regw_data_o = regw_data_i;
               end
            end
            BUSY: begin
               mem_req   = 1'b1;
               stall_mem = 1'b1;
            end
            DONE: begin
               write_o     = write_i;
               regw_addr_o = regw_addr_i;
               regw_data_o = store ? regw_data_i : load_ext;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

   logic        clock = 1'b0;
   logic        reset;
   logic        write_i;
   logic [4:0]  regw_addr_i;
   logic [31:0] regw_data_i;
   logic        load, store;
   logic [31:0] mem_write_data;
   logic [2:0]  mem_length;
   logic        mem_signed;
   logic        mem_ready;
   logic [7:0]  mem_rdata;
   logic        mem_req, mem_rw;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        stall_mem;
   logic        write_o;
   logic [4:0]  regw_addr_o;
   logic [31:0] regw_data_o;

   stage_mem #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clock(clock), .reset(reset), .write_i(write_i), .regw_addr_i(regw_addr_i),
      .regw_data_i(regw_data_i), .load(load), .store(store),
      .mem_write_data(mem_write_data), .mem_length(mem_length), .mem_signed(mem_signed),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_rw(mem_rw),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall_mem(stall_mem),
      .write_o(write_o), .regw_addr_o(regw_addr_o), .regw_data_o(regw_data_o));

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic        rw;
      logic [7:0]  wdata;
   } req_t;

   typedef struct {
      logic [4:0]  ra;
      logic [31:0] d;
   } res_t;

   req_t rq[$];
   res_t resq[$];

   int checks = 0;
   int errors = 0;

   logic [7:0] rb [4];
   int         wt [4];

   // Monitor: pops expectations whenever the DUT presents a byte handshake
   // or a retiring instruction (stall released with write_o high).
   always @(negedge clock) begin
      if (!reset) begin
         if (mem_req && mem_ready) begin
            checks++;
            if (rq.size() == 0) begin
               errors++;
               $display("FAIL req_unexpected: got addr=%h rw=%b, required none", mem_addr, mem_rw);
            end else begin
               req_t e;
               e = rq.pop_front();
               if (mem_addr !== e.addr || mem_rw !== e.rw || (e.rw && mem_wdata !== e.wdata)) begin
                  errors++;
                  $display("FAIL mem_req: got addr=%h rw=%b wdata=%h, required addr=%h rw=%b wdata=%h",
                           mem_addr, mem_rw, mem_wdata, e.addr, e.rw, e.wdata);
               end
            end
         end
         if (!stall_mem && write_o) begin
            checks++;
            if (resq.size() == 0) begin
               errors++;
               $display("FAIL result_unexpected: got rd=%0d data=%h, required none", regw_addr_o, regw_data_o);
            end else begin
               res_t r;
               r = resq.pop_front();
               if (regw_addr_o !== r.ra || regw_data_o !== r.d) begin
                  errors++;
                  $display("FAIL result: got rd=%0d data=%h, required rd=%0d data=%h",
                           regw_addr_o, regw_data_o, r.ra, r.d);
               end
            end
         end
      end
   end

   function automatic int len_of(input logic [2:0] ml);
      return (ml == 3'd1) ? 1 : (ml == 3'd2) ? 2 : 4;
   endfunction

   // Little-endian assemble, then sign-extend arithmetically by subtracting 2^(8L).
   function automatic logic [31:0] load_value(input int n, input bit sgn);
      longint v = 0;
      for (int i = 0; i < n; i++) v += longint'(rb[i]) << (8 * i);
      if (sgn && n < 4 && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
      return v[31:0];
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic bubble();
      write_i = 1'b0; load = 1'b0; store = 1'b0; mem_ready = 1'b0;
      regw_data_i = $urandom;
      next_cycle();
   endtask

   task automatic issue(input bit ld, input bit st, input logic [2:0] ml, input bit sg,
                        input logic [31:0] base, input logic [31:0] wd, input logic [4:0] rd);
      int   n;
      int   held;
      int   exp_stall;
      req_t e;
      res_t r;
      write_i = 1'b1; regw_addr_i = rd; regw_data_i = base; load = ld; store = st;
      mem_length = ml; mem_signed = sg; mem_write_data = wd;
      mem_ready = 1'b0; mem_rdata = $urandom;
      if (!ld && !st) begin
         r.ra = rd; r.d = base;
         resq.push_back(r);
         @(negedge clock);
         check("passthru_no_stall", {stall_mem, mem_req}, 64'd0);
         next_cycle();
         return;
      end
      n = len_of(ml);
      for (int i = 0; i < n; i++) begin
         e.addr  = base + 32'(i);
         e.rw    = st;
         e.wdata = wd[8*i +: 8];
         rq.push_back(e);
      end
      r.ra = rd;
      r.d  = st ? base : load_value(n, sg);
      resq.push_back(r);
      held = 0;
      exp_stall = 0;
      for (int i = 0; i < n; i++) begin
         for (int w = 0; w < wt[i]; w++) begin
            mem_ready = 1'b0; mem_rdata = $urandom;
            @(negedge clock);
            if (stall_mem && mem_req) held++;
            exp_stall++;
            next_cycle();
         end
         mem_ready = 1'b1; mem_rdata = rb[i];
         @(negedge clock);
         if (stall_mem && mem_req) held++;
         exp_stall++;
         next_cycle();
      end
      mem_ready = 1'b0;
      @(negedge clock);
      check("stall_cycles", 64'(held), 64'(exp_stall));
      check("done_released", {stall_mem, mem_req}, 64'd0);
      next_cycle();
   endtask

   task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      rb[0] = b0; rb[1] = b1; rb[2] = b2; rb[3] = b3;
   endtask

   task automatic no_waits();
      for (int i = 0; i < 4; i++) wt[i] = 0;
   endtask

   initial begin
      reset = 1'b1;
      write_i = 1'b1; regw_addr_i = 5'd3; regw_data_i = 32'h1234; load = 1'b1; store = 1'b0;
      mem_write_data = 32'd0; mem_length = 3'd4; mem_signed = 1'b0;
      mem_ready = 1'b1; mem_rdata = 8'hAA;
      no_waits();
      #1;
      check("reset_outputs", {mem_req, stall_mem, write_o, regw_data_o}, 64'd0);
      next_cycle();
      next_cycle();
      check("reset_outputs_clk", {mem_req, stall_mem, write_o, regw_addr_o, regw_data_o, mem_addr}, 64'd0);
      load = 1'b0;
      reset = 1'b0;
      bubble();

      // LW at 0x1000
      set_bytes(8'h78, 8'h56, 8'h34, 8'h12);
      issue(1, 0, 3'd4, 0, 32'h1000, 32'd0, 5'd1);
      // LB / LBU / LH
      set_bytes(8'h80, 8'h00, 8'h00, 8'h00);
      issue(1, 0, 3'd1, 1, 32'h20, 32'd0, 5'd2);
      issue(1, 0, 3'd1, 0, 32'h20, 32'd0, 5'd2);
      set_bytes(8'h34, 8'hF2, 8'h00, 8'h00);
      issue(1, 0, 3'd2, 1, 32'h20, 32'd0, 5'd3);
      // SH with two wait cycles before each byte
      wt[0] = 2; wt[1] = 2;
      issue(0, 1, 3'd2, 0, 32'h2002, 32'hDEADBEEF, 5'd4);
      no_waits();
      bubble();
      // ADD pass-through, then LW immediately followed by ADD
      issue(0, 0, 3'd4, 0, 32'h55, 32'd0, 5'd5);
      set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
      issue(1, 0, 3'd4, 0, 32'h300, 32'd0, 5'd6);
      issue(0, 0, 3'd4, 0, 32'h77, 32'd0, 5'd7);
      // LW across the address wrap
      set_bytes(8'h01, 8'h02, 8'h03, 8'h84);
      issue(1, 0, 3'd4, 1, 32'hFFFF_FFFE, 32'd0, 5'd8);

      // Reset during byte 2 of an LW
      begin
         req_t e;
         write_i = 1'b1; regw_addr_i = 5'd9; regw_data_i = 32'h4000; load = 1'b1; store = 1'b0;
         mem_length = 3'd4; mem_signed = 1'b0; mem_ready = 1'b1;
         for (int i = 0; i < 2; i++) begin
            e.addr = 32'h4000 + 32'(i); e.rw = 1'b0; e.wdata = 8'd0;
            rq.push_back(e);
         end
         next_cycle();
         next_cycle();
         check("byte2_presented", {mem_req, mem_addr}, {31'd0, 1'b1, 32'h4002});
         reset = 1'b1;
         #1;
         check("reset_midaccess", {mem_req, stall_mem, write_o, regw_addr_o, regw_data_o, mem_addr}, 64'd0);
         load = 1'b0; mem_ready = 1'b0;
         next_cycle();
         reset = 1'b0;
         issue(0, 0, 3'd4, 0, 32'hABC, 32'd0, 5'd10);
         set_bytes(8'hC3, 8'hB2, 8'hA1, 8'h90);
         issue(1, 0, 3'd4, 0, 32'h5000, 32'd0, 5'd11);
      end

      // Randomized instruction stream
      for (int t = 0; t < 60; t++) begin
         int k;
         logic [2:0] ml;
         logic [31:0] base;
         case ($urandom_range(0, 5))
            0: ml = 3'd1;
            1: ml = 3'd2;
            2: ml = 3'd4;
            3: ml = 3'd0;
            4: ml = 3'd3;
            default: ml = 3'd7;
         endcase
         base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
         for (int i = 0; i < 4; i++) begin
            wt[i] = $urandom_range(0, 2);
            rb[i] = 8'($urandom);
         end
         k = $urandom_range(0, 3);
         issue(k == 1 || k == 3, k >= 2, ml, 1'($urandom), base, $urandom, 5'($urandom));
         if ($urandom_range(0, 3) == 0) bubble();
      end

      bubble();
      bubble();
      check("req_queue_empty", 64'(rq.size()), 64'd0);
      check("res_queue_empty", 64'(resq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
